// File: rtl/order_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : order_dispatch_if
// Brief    : Menu selections in, dispense drives and status pulses out.
// Revision : 1.0
// ============================================================================
interface order_dispatch_if;
  logic [3:0] food;
  logic       food_act;
  logic [3:0] drink;
  logic       drink_act;
  logic [3:0] pay;
  logic       pay_act;
  logic       cancel;
  logic       busy;
  logic [5:0] total;
  logic [1:0] method;
  logic [3:0] serve_food;
  logic [3:0] serve_drink;
  logic       done;
  logic       abort;
  logic       err;

  modport slave (
    input  food, food_act, drink, drink_act, pay, pay_act, cancel,
    output busy, total, method, serve_food, serve_drink, done, abort, err
  );

  modport master (
    output food, food_act, drink, drink_act, pay, pay_act, cancel,
    input  busy, total, method, serve_food, serve_drink, done, abort, err
  );
endinterface
`default_nettype wire

// File: rtl/order_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : order_dispatch
// Brief    : Food/drink order FSM: select, price, pay, then timed dispense.
// Revision : 1.0
// ============================================================================
module order_dispatch #(
  parameter int DISP_CYCLES = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  order_dispatch_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_DRINK  = 3'd1,
    WAIT_PAY    = 3'd2,
    SERVE_FOOD  = 3'd3,
    SERVE_DRINK = 3'd4,
    DONE        = 3'd5
  } state_t;

  localparam logic [7:0] c_cnt_load = 8'(DISP_CYCLES - 1);

  function automatic logic [5:0] food_price(input logic [3:0] sel);
    case (sel)
      4'b0001: food_price = 6'd5;
      4'b0010: food_price = 6'd7;
      4'b0100: food_price = 6'd9;
      4'b1000: food_price = 6'd12;
      default: food_price = 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] drink_price(input logic [3:0] sel);
    case (sel)
      4'b0001: drink_price = 6'd2;
      4'b0010: drink_price = 6'd3;
      4'b0100: drink_price = 6'd4;
      4'b1000: drink_price = 6'd6;
      default: drink_price = 6'd0;
    endcase
  endfunction

  state_t     r_state;
  state_t     w_next;
  logic       r_food_d, r_drink_d, r_pay_d, r_primed;
  logic [3:0] r_food, r_drink;
  logic [5:0] r_total;
  logic [1:0] r_method;
  logic [7:0] r_cnt;
  logic       r_err, r_abort;

  logic w_food_edge, w_drink_edge, w_pay_edge;
  logic w_latch_food, w_latch_drink, w_latch_pay, w_clear, w_load_cnt, w_err, w_abort;
  logic [1:0] w_method;

  // r_primed masks the first cycle after reset so a level held high across release is not an edge
  assign w_food_edge  = r_primed & bus.food_act  & ~r_food_d;
  assign w_drink_edge = r_primed & bus.drink_act & ~r_drink_d;
  assign w_pay_edge   = r_primed & bus.pay_act   & ~r_pay_d;

  assign w_method = bus.pay[2] ? 2'd2 : (bus.pay[1] ? 2'd1 : 2'd0);

  always_comb begin
    w_next        = r_state;
    w_latch_food  = 1'b0;
    w_latch_drink = 1'b0;
    w_latch_pay   = 1'b0;
    w_clear       = 1'b0;
    w_load_cnt    = 1'b0;
    w_err         = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_food_edge) begin
          if ($onehot(bus.food)) begin
            w_latch_food = 1'b1;
            w_next       = WAIT_DRINK;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      WAIT_DRINK: begin
        if (bus.cancel) begin
          w_abort = 1'b1;
          w_clear = 1'b1;
          w_next  = IDLE;
        end else if (w_drink_edge) begin
          if ($onehot(bus.drink)) begin
            w_latch_drink = 1'b1;
            w_next        = WAIT_PAY;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      WAIT_PAY: begin
        if (bus.cancel) begin
          w_abort = 1'b1;
          w_clear = 1'b1;
          w_next  = IDLE;
        end else if (w_pay_edge) begin
          if (bus.pay == 4'b1000) begin
            w_abort = 1'b1;
            w_clear = 1'b1;
            w_next  = IDLE;
          end else if ($onehot(bus.pay)) begin
            w_latch_pay = 1'b1;
            w_load_cnt  = 1'b1;
            w_next      = SERVE_FOOD;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      SERVE_FOOD: begin
        if (r_cnt == 8'd0) begin
          w_load_cnt = 1'b1;
          w_next     = SERVE_DRINK;
        end
      end
      SERVE_DRINK: begin
        if (r_cnt == 8'd0) w_next = DONE;
      end
      DONE: begin
        w_clear = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_food_d  <= 1'b0;
      r_drink_d <= 1'b0;
      r_pay_d   <= 1'b0;
      r_primed  <= 1'b0;
      r_food    <= 4'd0;
      r_drink   <= 4'd0;
      r_total   <= 6'd0;
      r_method  <= 2'd0;
      r_cnt     <= 8'd0;
      r_err     <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_food_d  <= bus.food_act;
      r_drink_d <= bus.drink_act;
      r_pay_d   <= bus.pay_act;
      r_primed  <= 1'b1;
      r_err     <= w_err;
      r_abort   <= w_abort;
      if (w_clear) begin
        r_food   <= 4'd0;
        r_drink  <= 4'd0;
        r_total  <= 6'd0;
        r_method <= 2'd0;
      end else begin
        if (w_latch_food) r_food <= bus.food;
        if (w_latch_drink) begin
          r_drink <= bus.drink;
          r_total <= food_price(r_food) + drink_price(bus.drink);
        end
        if (w_latch_pay) r_method <= w_method;
      end
      if (w_load_cnt)
        r_cnt <= c_cnt_load;
      else if ((r_state == SERVE_FOOD || r_state == SERVE_DRINK) && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.total       = r_total;
  assign bus.method      = r_method;
  assign bus.serve_food  = (r_state == SERVE_FOOD)  ? r_food  : 4'd0;
  assign bus.serve_drink = (r_state == SERVE_DRINK) ? r_drink : 4'd0;
  assign bus.done        = (r_state == DONE);
  assign bus.abort       = r_abort;
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_order_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_order_dispatch
// Brief    : Directed self-checking bench for order_dispatch.
// Revision : 1.0
// ============================================================================
module tb_order_dispatch;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  order_dispatch_if bus();

  order_dispatch #(.DISP_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_wait_pay(input logic [3:0] f, input logic [3:0] d);
    bus.food = f;  bus.food_act = 1'b1;  tick();  bus.food_act = 1'b0;
    bus.drink = d; bus.drink_act = 1'b1; tick();  bus.drink_act = 1'b0;
  endtask

  task automatic send_pay(input logic [3:0] p);
    bus.pay = p; bus.pay_act = 1'b1; tick(); bus.pay_act = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.total, bus.method, bus.serve_food, bus.serve_drink,
         bus.done, bus.abort, bus.err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b total=%0d serve=%b/%b done=%b abort=%b err=%b, want all 0",
               bus.busy, bus.total, bus.serve_food, bus.serve_drink, bus.done, bus.abort, bus.err);
    end
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_full_order();
    int n;
    int overlap;
    go_wait_pay(4'b0010, 4'b0100);
    checks++;
    if (bus.total !== 6'd11) begin
      errors++; $display("FAIL total_7_4: got %0d want 11", bus.total);
    end
    send_pay(4'b0010);
    checks++;
    if (bus.method !== 2'd1) begin
      errors++; $display("FAIL method_card: got %0d want 1", bus.method);
    end
    n = 0; overlap = 0;
    while (bus.serve_food != 4'd0 && n < 40) begin
      if (bus.serve_food !== 4'b0010 || bus.serve_drink !== 4'd0) overlap++;
      n++; tick();
    end
    checks++;
    if (n !== 8 || overlap !== 0) begin
      errors++; $display("FAIL serve_food_len: got %0d cycles (bad %0d) want 8", n, overlap);
    end
    n = 0; overlap = 0;
    while (bus.serve_drink != 4'd0 && n < 40) begin
      if (bus.serve_drink !== 4'b0100 || bus.serve_food !== 4'd0) overlap++;
      n++; tick();
    end
    checks++;
    if (n !== 8 || overlap !== 0) begin
      errors++; $display("FAIL serve_drink_len: got %0d cycles (bad %0d) want 8", n, overlap);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL done_pulse: got %b want 1", bus.done);
    end
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.total} !== 8'd0) begin
      errors++; $display("FAIL after_done: got done=%b busy=%b total=%0d want 0 0 0",
                         bus.done, bus.busy, bus.total);
    end
  endtask

  task automatic test_bad_food();
    bus.food = 4'b0110; bus.food_act = 1'b1; tick(); bus.food_act = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bad_food_err: got err=%b busy=%b want 1 0", bus.err, bus.busy);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bad_food_pulse: got err=%b busy=%b want 0 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_ignored_edges();
    // drink edge in IDLE with a bad vector must not raise err
    bus.drink = 4'b0011; bus.drink_act = 1'b1; tick(); bus.drink_act = 1'b0;
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_drink_edge: got err=%b busy=%b want 0 0", bus.err, bus.busy);
    end
    bus.cancel = 1'b1; tick(); tick(); bus.cancel = 1'b0;
    checks++;
    if (bus.abort !== 1'b0) begin
      errors++; $display("FAIL idle_cancel: got abort=%b want 0", bus.abort);
    end
  endtask

  task automatic test_cancel_vs_pay();
    go_wait_pay(4'b0001, 4'b0001);
    checks++;
    if (bus.total !== 6'd7) begin
      errors++; $display("FAIL total_5_2: got %0d want 7", bus.total);
    end
    send_pay(4'b0011);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL bad_pay_err: got err=%b busy=%b want 1 1", bus.err, bus.busy);
    end
    tick();
    bus.cancel = 1'b1;
    send_pay(4'b0001);
    bus.cancel = 1'b0;
    checks++;
    if ({bus.abort, bus.busy, bus.total, bus.serve_food} !== {1'b1, 1'b0, 6'd0, 4'd0}) begin
      errors++; $display("FAIL cancel_priority: got abort=%b busy=%b total=%0d serve=%b want 1 0 0 0000",
                         bus.abort, bus.busy, bus.total, bus.serve_food);
    end
    tick();
    checks++;
    if (bus.abort !== 1'b0) begin
      errors++; $display("FAIL abort_pulse: got %b want 0", bus.abort);
    end
  endtask

  task automatic test_finish_no_pay();
    int seen;
    go_wait_pay(4'b0100, 4'b0010);
    checks++;
    if (bus.total !== 6'd12) begin
      errors++; $display("FAIL total_9_3: got %0d want 12", bus.total);
    end
    send_pay(4'b1000);
    checks++;
    if (bus.abort !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL finish_abort: got abort=%b busy=%b want 1 0", bus.abort, bus.busy);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.serve_food != 4'd0 || bus.serve_drink != 4'd0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL finish_no_serve: got %0d serve cycles want 0", seen);
    end
  endtask

  task automatic test_max_total_cancel_serve();
    int n;
    go_wait_pay(4'b1000, 4'b1000);
    checks++;
    if (bus.total !== 6'd18) begin
      errors++; $display("FAIL total_max: got %0d want 18", bus.total);
    end
    send_pay(4'b0001);
    checks++;
    if (bus.method !== 2'd0 || bus.serve_food !== 4'b1000) begin
      errors++; $display("FAIL cash_serve: got method=%0d serve_food=%b want 0 1000",
                         bus.method, bus.serve_food);
    end
    n = 0;
    while (bus.serve_food != 4'd0 && n < 40) begin n++; tick(); end
    bus.cancel = 1'b1;
    n = 0;
    while (bus.serve_drink != 4'd0 && n < 40) begin n++; tick(); end
    bus.cancel = 1'b0;
    checks++;
    if (n !== 8 || bus.done !== 1'b1) begin
      errors++; $display("FAIL cancel_in_serve: got %0d drink cycles done=%b want 8 1", n, bus.done);
    end
    tick();
  endtask

  task automatic test_reset_mid_dispense();
    go_wait_pay(4'b0001, 4'b0010);
    send_pay(4'b0100);
    tick();
    tick();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.total, bus.method, bus.serve_food, bus.serve_drink,
         bus.done, bus.abort, bus.err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_serve: got busy=%b total=%0d serve=%b/%b done=%b, want all 0",
               bus.busy, bus.total, bus.serve_food, bus.serve_drink, bus.done);
    end
    bus.food = 4'b0001; bus.food_act = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL held_act_release: got busy=%b err=%b done=%b want 0 0 0",
                         bus.busy, bus.err, bus.done);
    end
    bus.food_act = 1'b0; tick();
    bus.food_act = 1'b1; tick(); bus.food_act = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL fresh_edge: got busy=%b want 1", bus.busy);
    end
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    checks++;
    if (bus.abort !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL cancel_wait_drink: got abort=%b busy=%b want 1 0", bus.abort, bus.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.food = 4'd0; bus.food_act = 1'b0;
    bus.drink = 4'd0; bus.drink_act = 1'b0;
    bus.pay = 4'd0; bus.pay_act = 1'b0;
    bus.cancel = 1'b0;
    test_reset();
    test_full_order();
    test_bad_food();
    test_ignored_edges();
    test_cancel_vs_pay();
    test_finish_no_pay();
    test_max_total_cancel_serve();
    test_reset_mid_dispense();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/order_dispatch.md
ORDER_DISPATCH -- requirements
Module: order_dispatch

Interface
REQ-001 Parameter DISP_CYCLES, default 8: number of clk cycles each serve output stays asserted; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 food  input  4  one-hot food choice from the food menu (bit0..bit3 = option 1..4).
REQ-005 food_act  input  1  food menu completion level; its rising edge means food is valid.
REQ-006 drink  input  4  one-hot drink choice from the drink menu.
REQ-007 drink_act  input  1  drink menu completion level; its rising edge means drink is valid.
REQ-008 pay  input  4  one-hot payment choice: bit0 cash, bit1 card, bit2 recharge, bit3 finish-without-paying.
REQ-009 pay_act  input  1  payment completion level; its rising edge means pay is valid.
REQ-010 cancel  input  1  synchronous cancel request, level, already debounced.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 total  output  6  order price in credits, valid from WAIT_PAY onward.
REQ-013 method  output  2  latched payment method (0 cash, 1 card, 2 recharge).
REQ-014 serve_food  output  4  one-hot food dispense drive.
REQ-015 serve_drink  output  4  one-hot drink dispense drive.
REQ-016 done  output  1  one-cycle pulse on order completion.
REQ-017 abort  output  1  one-cycle pulse on cancel or finish-without-paying.
REQ-018 err  output  1  one-cycle pulse when a sampled selection vector is not exactly one-hot.

Function
REQ-019 Rising edges of food_act, drink_act, pay_act SHALL be detected by registering each input once; an edge is seen the cycle after the level goes high; a level already high at reset release SHALL NOT count as an edge.
REQ-020 FSM states SHALL be IDLE, WAIT_DRINK, WAIT_PAY, SERVE_FOOD, SERVE_DRINK, DONE.
REQ-021 IDLE: food_act edge with one-hot food -> latch food, go WAIT_DRINK; non-one-hot -> err pulse, stay IDLE.
REQ-022 WAIT_DRINK: drink_act edge with one-hot drink -> latch drink, load total, go WAIT_PAY; non-one-hot -> err pulse, stay.
REQ-023 Prices: food 5,7,9,12; drink 2,3,4,6; total = food price + drink price, unsigned 6 bits, maximum 18, no overflow.
REQ-024 WAIT_PAY: pay_act edge with pay one-hot in bits 0..2 -> latch method, go SERVE_FOOD; pay = 4'b1000 -> abort pulse, go IDLE; non-one-hot -> err pulse, stay.
REQ-025 SERVE_FOOD: serve_food = latched food for exactly DISP_CYCLES cycles, then SERVE_DRINK.
REQ-026 SERVE_DRINK: serve_drink = latched drink for exactly DISP_CYCLES cycles, then DONE; serve_food and serve_drink never both nonzero.
REQ-027 DONE: done high for one cycle, latches and total cleared, next state IDLE.
REQ-028 cancel high in WAIT_DRINK or WAIT_PAY -> abort pulse, latches and total cleared, IDLE next cycle; cancel has priority over any same-cycle act edge.
REQ-029 cancel in IDLE SHALL be ignored (no abort pulse); cancel in SERVE_FOOD, SERVE_DRINK, DONE SHALL be ignored (dispense completes).
REQ-030 act edges arriving in any state other than the one consuming them SHALL be ignored, with no err.
REQ-031 Dispense counter SHALL be 8 bits, load at state entry, no wrap-around beyond DISP_CYCLES.

Reset
REQ-032 reset high SHALL immediately force IDLE; busy, total, method, serve_food, serve_drink, done, abort, err, edge registers, latches and counter all 0.
REQ-033 reset asserted mid-dispense SHALL drop serve outputs asynchronously with no done pulse.

Verification
REQ-034 food=0010 edge, drink=0100 edge, pay=0010 edge -> total=11, method=1, serve_food=0010 for 8 cycles, serve_drink=0100 for 8 cycles, done pulse once, busy low after.
REQ-035 food=0110 with food_act edge -> err pulse one cycle, state stays IDLE, busy=0.
REQ-036 In WAIT_PAY, cancel and pay_act edge same cycle -> abort pulse, no serve, total=0 next cycle.
REQ-037 In WAIT_PAY, pay=1000 edge -> abort pulse, IDLE, serve outputs never asserted.
REQ-038 food=1000, drink=1000 -> total=18; cancel during SERVE_DRINK ignored, done still pulses.
REQ-039 reset asserted on cycle 3 of SERVE_FOOD -> all outputs 0 same cycle; food_act held high at release produces no transition.
